// File: rtl/simple_bus_pkg.sv
// Shared SimpleBus widths and master source IDs for the RAM arbiter slice.
// The command struct groups one cmd beat so the monitor side can compare whole beats.
package simple_bus_pkg;

  localparam int SB_ADDR_W = 32;
  localparam int SB_DATA_W = 32;
  localparam int SB_MASK_W = SB_DATA_W / 8;

  localparam logic SRC_IBUS = 1'b0;
  localparam logic SRC_DBUS = 1'b1;

  typedef struct packed {
    logic                 write;
    logic [SB_ADDR_W-1:0] address;
    logic [SB_DATA_W-1:0] data;
    logic [SB_MASK_W-1:0] mask;
  } sb_cmd_t;

endpackage

// File: rtl/simple_bus_src_fifo.sv
// In-order FIFO of 1-bit source IDs, one entry per read in flight.
// Occupancy is tracked separately so full and empty never alias when the pointers meet.
module simple_bus_src_fifo #(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic push_id,
  input  logic pop,
  output logic head_id,
  output logic full,
  output logic empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DEPTH-1:0] mem_r;
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign full      = (count_r == CNT_W'(DEPTH));
  assign empty     = (count_r == {CNT_W{1'b0}});
  assign push_ok_s = push & ~full;
  assign pop_ok_s  = pop & ~empty;
  assign head_id   = mem_r[rd_ptr_r];

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= push_id;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/simple_bus_ram_arbiter.sv
// Round-robin 2:1 SimpleBus arbiter in front of one on-chip RAM slave.
// Read source IDs are queued in order so each rsp beat returns to its issuer.
module simple_bus_ram_arbiter
  import simple_bus_pkg::*;
#(
  parameter int ADDR_W        = SB_ADDR_W,
  parameter int DATA_W        = SB_DATA_W,
  parameter int PENDING_DEPTH = 4
) (
  input  logic                io_mainClk,
  input  logic                resetCtrl_systemReset,
  input  logic                io_m0_cmd_valid,
  output logic                io_m0_cmd_ready,
  input  logic                io_m0_cmd_payload_write,
  input  logic [ADDR_W-1:0]   io_m0_cmd_payload_address,
  input  logic [DATA_W-1:0]   io_m0_cmd_payload_data,
  input  logic [DATA_W/8-1:0] io_m0_cmd_payload_mask,
  output logic                io_m0_rsp_valid,
  output logic [DATA_W-1:0]   io_m0_rsp_payload_data,
  input  logic                io_m1_cmd_valid,
  output logic                io_m1_cmd_ready,
  input  logic                io_m1_cmd_payload_write,
  input  logic [ADDR_W-1:0]   io_m1_cmd_payload_address,
  input  logic [DATA_W-1:0]   io_m1_cmd_payload_data,
  input  logic [DATA_W/8-1:0] io_m1_cmd_payload_mask,
  output logic                io_m1_rsp_valid,
  output logic [DATA_W-1:0]   io_m1_rsp_payload_data,
  output logic                io_s_cmd_valid,
  input  logic                io_s_cmd_ready,
  output logic                io_s_cmd_payload_write,
  output logic [ADDR_W-1:0]   io_s_cmd_payload_address,
  output logic [DATA_W-1:0]   io_s_cmd_payload_data,
  output logic [DATA_W/8-1:0] io_s_cmd_payload_mask,
  input  logic                io_s_rsp_valid,
  input  logic [DATA_W-1:0]   io_s_rsp_payload_data,
  output logic                io_rspOrphan
);

  logic rr_ptr_r;
  logic rsp_orphan_r;
  logic fifo_full_s;
  logic fifo_empty_s;
  logic head_id_s;
  logic elig0_s;
  logic elig1_s;
  logic gnt_vld_s;
  logic gnt_id_s;
  logic fire_s;
  logic push_s;
  logic pop_s;

  // A read that cannot be queued drops out of arbitration so the other master can use the slot.
  assign elig0_s = io_m0_cmd_valid & (io_m0_cmd_payload_write | ~fifo_full_s);
  assign elig1_s = io_m1_cmd_valid & (io_m1_cmd_payload_write | ~fifo_full_s);

  // Grant selection: a lone eligible master wins, a tie goes to the round-robin pointer.
  always_comb begin
    gnt_vld_s = 1'b0;
    gnt_id_s  = SRC_IBUS;
    case ({elig1_s, elig0_s})
      2'b01: begin
        gnt_vld_s = 1'b1;
        gnt_id_s  = SRC_IBUS;
      end
      2'b10: begin
        gnt_vld_s = 1'b1;
        gnt_id_s  = SRC_DBUS;
      end
      2'b11: begin
        gnt_vld_s = 1'b1;
        gnt_id_s  = rr_ptr_r;
      end
      default: begin
        gnt_vld_s = 1'b0;
        gnt_id_s  = SRC_IBUS;
      end
    endcase
  end

  // Forward the granted master's payload to the slave with no added latency.
  always_comb begin
    io_s_cmd_payload_write   = 1'b0;
    io_s_cmd_payload_address = {ADDR_W{1'b0}};
    io_s_cmd_payload_data    = {DATA_W{1'b0}};
    io_s_cmd_payload_mask    = {(DATA_W/8){1'b0}};
    if (gnt_id_s == SRC_DBUS) begin
      io_s_cmd_payload_write   = io_m1_cmd_payload_write;
      io_s_cmd_payload_address = io_m1_cmd_payload_address;
      io_s_cmd_payload_data    = io_m1_cmd_payload_data;
      io_s_cmd_payload_mask    = io_m1_cmd_payload_mask;
    end else begin
      io_s_cmd_payload_write   = io_m0_cmd_payload_write;
      io_s_cmd_payload_address = io_m0_cmd_payload_address;
      io_s_cmd_payload_data    = io_m0_cmd_payload_data;
      io_s_cmd_payload_mask    = io_m0_cmd_payload_mask;
    end
  end

  assign io_s_cmd_valid  = gnt_vld_s;
  assign io_m0_cmd_ready = gnt_vld_s & (gnt_id_s == SRC_IBUS) & io_s_cmd_ready;
  assign io_m1_cmd_ready = gnt_vld_s & (gnt_id_s == SRC_DBUS) & io_s_cmd_ready;
  assign fire_s          = gnt_vld_s & io_s_cmd_ready;
  assign push_s          = fire_s & ~io_s_cmd_payload_write;

  // Responses follow the FIFO head; one arriving with nothing pending is dropped.
  assign pop_s                  = io_s_rsp_valid & ~fifo_empty_s;
  assign io_m0_rsp_valid        = pop_s & (head_id_s == SRC_IBUS);
  assign io_m1_rsp_valid        = pop_s & (head_id_s == SRC_DBUS);
  assign io_m0_rsp_payload_data = io_s_rsp_payload_data;
  assign io_m1_rsp_payload_data = io_s_rsp_payload_data;
  assign io_rspOrphan           = rsp_orphan_r;

  // Round-robin pointer favours the master that did not win the last fired beat.
  always_ff @(posedge io_mainClk) begin
    if (resetCtrl_systemReset) begin
      rr_ptr_r <= SRC_IBUS;
    end else if (fire_s) begin
      rr_ptr_r <= ~gnt_id_s;
    end else begin
      rr_ptr_r <= rr_ptr_r;
    end
  end

  // Sticky orphan flag, cleared only by reset.
  always_ff @(posedge io_mainClk) begin
    if (resetCtrl_systemReset) begin
      rsp_orphan_r <= 1'b0;
    end else if (io_s_rsp_valid & fifo_empty_s) begin
      rsp_orphan_r <= 1'b1;
    end else begin
      rsp_orphan_r <= rsp_orphan_r;
    end
  end

  simple_bus_src_fifo #(
    .DEPTH(PENDING_DEPTH)
  ) u_src_fifo (
    .clk    (io_mainClk),
    .rst    (resetCtrl_systemReset),
    .push   (push_s),
    .push_id(gnt_id_s),
    .pop    (pop_s),
    .head_id(head_id_s),
    .full   (fifo_full_s),
    .empty  (fifo_empty_s)
  );

endmodule

// File: tb/tb_simple_bus_ram_arbiter.sv
// Scoreboard bench: stimulus queues expected slave beats and master responses,
// a negedge monitor compares them whenever the DUT presents a beat.
module tb_simple_bus_ram_arbiter;
  import simple_bus_pkg::*;

  typedef struct packed {
    logic        id;
    logic        write;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  mask;
  } cmd_t;

  logic        io_mainClk = 1'b0;
  logic        resetCtrl_systemReset;
  logic        m_valid [2];
  logic        m_write [2];
  logic [31:0] m_addr  [2];
  logic [31:0] m_data  [2];
  logic [3:0]  m_mask  [2];
  logic        m0_cmd_ready, m1_cmd_ready;
  logic        m0_rsp_valid, m1_rsp_valid;
  logic [31:0] m0_rsp_data, m1_rsp_data;
  logic        s_cmd_valid, s_write;
  logic        s_cmd_ready = 1'b1;
  logic [31:0] s_addr, s_data;
  logic [3:0]  s_mask;
  logic        s_rsp_valid = 1'b0;
  logic [31:0] s_rsp_data = 32'h0;
  logic        rsp_orphan;

  logic        hold_rsp = 1'b0;
  logic        inject_rsp = 1'b0;
  int          total = 0;
  int          bad = 0;

  cmd_t        drv_q0 [$];
  cmd_t        drv_q1 [$];
  cmd_t        exp_cmd_q [$];
  logic [31:0] exp_rsp0_q [$];
  logic [31:0] exp_rsp1_q [$];
  logic [31:0] ram_q [$];

  simple_bus_ram_arbiter dut (
    .io_mainClk               (io_mainClk),
    .resetCtrl_systemReset    (resetCtrl_systemReset),
    .io_m0_cmd_valid          (m_valid[0]),
    .io_m0_cmd_ready          (m0_cmd_ready),
    .io_m0_cmd_payload_write  (m_write[0]),
    .io_m0_cmd_payload_address(m_addr[0]),
    .io_m0_cmd_payload_data   (m_data[0]),
    .io_m0_cmd_payload_mask   (m_mask[0]),
    .io_m0_rsp_valid          (m0_rsp_valid),
    .io_m0_rsp_payload_data   (m0_rsp_data),
    .io_m1_cmd_valid          (m_valid[1]),
    .io_m1_cmd_ready          (m1_cmd_ready),
    .io_m1_cmd_payload_write  (m_write[1]),
    .io_m1_cmd_payload_address(m_addr[1]),
    .io_m1_cmd_payload_data   (m_data[1]),
    .io_m1_cmd_payload_mask   (m_mask[1]),
    .io_m1_rsp_valid          (m1_rsp_valid),
    .io_m1_rsp_payload_data   (m1_rsp_data),
    .io_s_cmd_valid           (s_cmd_valid),
    .io_s_cmd_ready           (s_cmd_ready),
    .io_s_cmd_payload_write   (s_write),
    .io_s_cmd_payload_address (s_addr),
    .io_s_cmd_payload_data    (s_data),
    .io_s_cmd_payload_mask    (s_mask),
    .io_s_rsp_valid           (s_rsp_valid),
    .io_s_rsp_payload_data    (s_rsp_data),
    .io_rspOrphan             (rsp_orphan)
  );

  always #5 io_mainClk = ~io_mainClk;

  // RAM contents seen by the slave model.
  function automatic logic [31:0] rd_data(input logic [31:0] addr);
    if (addr == 32'h0000_0010) return 32'hDEAD_BEEF;
    return {16'hC0DE, addr[15:0]};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic issue(input int m, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] k);
    cmd_t c;
    c = '{id: m[0], write: w, addr: a, data: d, mask: k};
    if (m == 0) drv_q0.push_back(c);
    else drv_q1.push_back(c);
    if (!w && m == 0) exp_rsp0_q.push_back(rd_data(a));
    if (!w && m == 1) exp_rsp1_q.push_back(rd_data(a));
  endtask

  task automatic exp_cmd(input int m, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] k);
    exp_cmd_q.push_back('{id: m[0], write: w, addr: a, data: d, mask: k});
  endtask

  task automatic wait_drain(input int max_cycles);
    int n;
    n = 0;
    while ((drv_q0.size() + drv_q1.size() + exp_cmd_q.size() + exp_rsp0_q.size()
            + exp_rsp1_q.size() + ram_q.size()) != 0 && n < max_cycles) begin
      @(negedge io_mainClk);
      n++;
    end
    if (n >= max_cycles) check("drain_timeout", 128'(exp_cmd_q.size() + exp_rsp0_q.size()
                                                    + exp_rsp1_q.size()), 128'd0);
  endtask

  task automatic do_reset();
    @(negedge io_mainClk);
    resetCtrl_systemReset = 1'b1;
    repeat (2) @(negedge io_mainClk);
    resetCtrl_systemReset = 1'b0;
    @(negedge io_mainClk);
  endtask

  // Master drivers: hold each beat until accepted, then present the next one.
  logic acc0, acc1;
  always begin
    @(posedge io_mainClk);
    acc0 = m_valid[0] & m0_cmd_ready;
    acc1 = m_valid[1] & m1_cmd_ready;
    #1;
    if (acc0 && drv_q0.size() > 0) void'(drv_q0.pop_front());
    if (acc1 && drv_q1.size() > 0) void'(drv_q1.pop_front());
    m_valid[0] = (drv_q0.size() > 0);
    m_write[0] = (drv_q0.size() > 0) ? drv_q0[0].write : 1'b0;
    m_addr[0]  = (drv_q0.size() > 0) ? drv_q0[0].addr  : 32'h0;
    m_data[0]  = (drv_q0.size() > 0) ? drv_q0[0].data  : 32'h0;
    m_mask[0]  = (drv_q0.size() > 0) ? drv_q0[0].mask  : 4'h0;
    m_valid[1] = (drv_q1.size() > 0);
    m_write[1] = (drv_q1.size() > 0) ? drv_q1[0].write : 1'b0;
    m_addr[1]  = (drv_q1.size() > 0) ? drv_q1[0].addr  : 32'h0;
    m_data[1]  = (drv_q1.size() > 0) ? drv_q1[0].data  : 32'h0;
    m_mask[1]  = (drv_q1.size() > 0) ? drv_q1[0].mask  : 4'h0;
  end

  // RAM slave model: one-cycle read latency, responses can be held off or injected.
  logic        sl_fire, sl_inj;
  logic [31:0] sl_addr;
  always begin
    @(posedge io_mainClk);
    sl_fire = s_cmd_valid & s_cmd_ready & ~s_write & ~resetCtrl_systemReset;
    sl_addr = s_addr;
    sl_inj  = inject_rsp;
    #1;
    if (sl_fire) ram_q.push_back(rd_data(sl_addr));
    if (sl_inj) begin
      s_rsp_valid = 1'b1;
      s_rsp_data  = 32'h0BAD_0BAD;
    end else if (!hold_rsp && !resetCtrl_systemReset && ram_q.size() > 0) begin
      s_rsp_valid = 1'b1;
      s_rsp_data  = ram_q.pop_front();
    end else begin
      s_rsp_valid = 1'b0;
      s_rsp_data  = 32'h0;
    end
  end

  // Monitor: compare every fired slave beat and every master response against the scoreboard.
  cmd_t        mon_act, mon_exp;
  logic [31:0] mon_rsp;
  always @(negedge io_mainClk) begin
    if (!resetCtrl_systemReset) begin
      if (s_cmd_valid && s_cmd_ready) begin
        check("ready_onehot", 128'(m0_cmd_ready ^ m1_cmd_ready), 128'd1);
        mon_act = '{id: m1_cmd_ready, write: s_write, addr: s_addr, data: s_data, mask: s_mask};
        if (exp_cmd_q.size() == 0) begin
          check("unexpected_cmd", 128'(mon_act), 128'd0);
        end else begin
          mon_exp = exp_cmd_q.pop_front();
          check("slave_cmd", 128'(mon_act), 128'(mon_exp));
        end
      end
      if (m0_rsp_valid) begin
        if (exp_rsp0_q.size() == 0) check("unexpected_m0_rsp", 128'(m0_rsp_data), 128'd0);
        else begin
          mon_rsp = exp_rsp0_q.pop_front();
          check("m0_rsp_data", 128'(m0_rsp_data), 128'(mon_rsp));
        end
      end
      if (m1_rsp_valid) begin
        if (exp_rsp1_q.size() == 0) check("unexpected_m1_rsp", 128'(m1_rsp_data), 128'd0);
        else begin
          mon_rsp = exp_rsp1_q.pop_front();
          check("m1_rsp_data", 128'(m1_rsp_data), 128'(mon_rsp));
        end
      end
    end
  end

  initial begin
    resetCtrl_systemReset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      m_valid[i] = 1'b0; m_write[i] = 1'b0; m_addr[i] = 32'h0; m_data[i] = 32'h0; m_mask[i] = 4'h0;
    end
    repeat (3) @(negedge io_mainClk);
    resetCtrl_systemReset = 1'b0;
    @(negedge io_mainClk);

    // Idle after reset
    check("t1_idle_outs", {124'd0, s_cmd_valid, m0_cmd_ready, m1_cmd_ready, m0_rsp_valid}, 128'd0);
    check("t1_idle_rsp1_orphan", {126'd0, m1_rsp_valid, rsp_orphan}, 128'd0);

    // Single m0 read, one-cycle latency
    issue(0, 1'b0, 32'h10, 32'h0, 4'hF);
    exp_cmd(0, 1'b0, 32'h10, 32'h0, 4'hF);
    @(posedge io_mainClk);
    @(negedge io_mainClk);
    check("t2_m0_ready_c0", 128'(m0_cmd_ready), 128'd1);
    @(negedge io_mainClk);
    check("t2_rsp_c1", {94'd0, m0_rsp_valid, m1_rsp_valid, m0_rsp_data}, {94'd0, 2'b10, 32'hDEAD_BEEF});
    wait_drain(20);

    // Both masters stream reads: alternating grants starting with m0
    do_reset();
    for (int i = 0; i < 4; i++) begin
      issue(0, 1'b0, 32'h100 + 32'(8 * i), 32'h0, 4'hF);
      issue(1, 1'b0, 32'h200 + 32'(8 * i), 32'h0, 4'hF);
      exp_cmd(0, 1'b0, 32'h100 + 32'(8 * i), 32'h0, 4'hF);
      exp_cmd(1, 1'b0, 32'h200 + 32'(8 * i), 32'h0, 4'hF);
    end
    wait_drain(40);

    // Stalled responses: fifth m1 read blocks, m0 write still passes
    do_reset();
    hold_rsp = 1'b1;
    for (int i = 0; i < 5; i++) issue(1, 1'b0, 32'h300 + 32'(4 * i), 32'h0, 4'hF);
    for (int i = 0; i < 4; i++) exp_cmd(1, 1'b0, 32'h300 + 32'(4 * i), 32'h0, 4'hF);
    repeat (7) @(negedge io_mainClk);
    check("t4_fifth_blocked", {125'd0, m_valid[1], m1_cmd_ready, s_cmd_valid}, {125'd0, 3'b100});
    issue(0, 1'b1, 32'h400, 32'h55, 4'b0001);
    exp_cmd(0, 1'b1, 32'h400, 32'h55, 4'b0001);
    exp_cmd(1, 1'b0, 32'h310, 32'h0, 4'hF);
    @(posedge io_mainClk);
    @(negedge io_mainClk);
    check("t4_write_passes", {126'd0, m0_cmd_ready, m1_cmd_ready}, {126'd0, 2'b10});
    repeat (2) @(negedge io_mainClk);
    hold_rsp = 1'b0;
    wait_drain(40);

    // m1 write alone: same-cycle forwarding, no response
    issue(1, 1'b1, 32'h500, 32'hA5A5_A5A5, 4'b1100);
    exp_cmd(1, 1'b1, 32'h500, 32'hA5A5_A5A5, 4'b1100);
    @(posedge io_mainClk);
    @(negedge io_mainClk);
    check("t5_write_fwd", {59'd0, s_cmd_valid, s_write, s_addr, s_data, s_mask},
          {59'd0, 2'b11, 32'h500, 32'hA5A5_A5A5, 4'b1100});
    wait_drain(20);
    check("t5_no_orphan", 128'(rsp_orphan), 128'd0);

    // Response with nothing pending sets the sticky orphan flag
    inject_rsp = 1'b1;
    @(negedge io_mainClk);
    inject_rsp = 1'b0;
    check("t6_orphan_dropped", {125'd0, s_rsp_valid, m0_rsp_valid, m1_rsp_valid}, {125'd0, 3'b100});
    @(negedge io_mainClk);
    check("t6_orphan_set", 128'(rsp_orphan), 128'd1);
    repeat (3) @(negedge io_mainClk);
    check("t6_orphan_sticky", 128'(rsp_orphan), 128'd1);
    do_reset();
    check("t6_orphan_cleared", 128'(rsp_orphan), 128'd0);

    // Reset with reads in flight: late responses become orphans
    hold_rsp = 1'b1;
    issue(0, 1'b0, 32'h600, 32'h0, 4'hF);
    issue(1, 1'b0, 32'h604, 32'h0, 4'hF);
    exp_cmd(0, 1'b0, 32'h600, 32'h0, 4'hF);
    exp_cmd(1, 1'b0, 32'h604, 32'h0, 4'hF);
    repeat (4) @(negedge io_mainClk);
    check("t6_burst_issued", 128'(exp_cmd_q.size()), 128'd0);
    do_reset();
    exp_rsp0_q.delete();
    exp_rsp1_q.delete();
    hold_rsp = 1'b0;
    repeat (4) @(negedge io_mainClk);
    check("t6_late_rsp_orphan", 128'(rsp_orphan), 128'd1);
    wait_drain(20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
